// File: rtl/mem_access_pkg.sv
// Shared encodings and constants for the data-memory access stage.
package mem_access_pkg;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_REQ  = 2'd1,
    MA_DONE = 2'd2
  } ma_state_e;

  localparam int          MA_TIMEOUT_DEFAULT = 255;
  localparam logic [31:0] MA_TIMEOUT_FILL    = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_timeout_timer.sv
// REQ-phase watchdog: counts enabled cycles since clear, flags the LIMIT-th one.
module mem_timeout_timer
  import mem_access_pkg::*;
#(
  parameter int LIMIT = MA_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count 0 is the first enabled cycle, so LIMIT-1 marks the LIMIT-th.
  assign expired_o = en_i && (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                  cnt_d = '0;
    else if (en_i && !expired_o)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Runs single-cycle CPU loads/stores as req/ack bus cycles, stalling the CPU meanwhile.
// Optional REQ timeout abort is built when MEM_TIMEOUT_EN is defined.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = MA_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_mem_ren,
  input  logic                  cpu_mem_wen,
  input  logic [ADDR_WIDTH-1:0] cpu_mem_addr,
  input  logic [DATA_WIDTH-1:0] cpu_mem_dout,
  output logic [DATA_WIDTH-1:0] cpu_mem_din,
  output logic                  cpu_stall,
  output logic                  misalign,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ack,
  output logic                  bus_err
);

  ma_state_e             state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  mis_q, mis_d;
  logic                  err_q, err_d;
  logic                  cpu_req;
  logic                  timeout;

  assign cpu_req = cpu_mem_ren | cpu_mem_wen;

`ifdef MEM_TIMEOUT_EN
  mem_timeout_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   ((state_q == MA_IDLE) && (state_d == MA_REQ)),
    .en_i      (state_q == MA_REQ),
    .expired_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    din_d   = din_q;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      MA_IDLE: if (cpu_req) begin
        we_d    = cpu_mem_wen;
        addr_d  = cpu_mem_addr;
        wdata_d = cpu_mem_dout;
        if (cpu_mem_addr[1:0] != 2'b00) begin
          // Misaligned: no bus cycle; a load returns zero, a store is dropped.
          state_d = MA_DONE;
          mis_d   = 1'b1;
          if (!cpu_mem_wen) din_d = '0;
        end else begin
          state_d = MA_REQ;
        end
      end
      MA_REQ: begin
        if (bus_ack) begin
          if (!we_q) din_d = bus_rdata;
          state_d = MA_DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          din_d   = DATA_WIDTH'(MA_TIMEOUT_FILL);
          state_d = MA_DONE;
        end
      end
      // CPU inputs still show the finished access here, so they are not looked at.
      MA_DONE: state_d = MA_IDLE;
      default: state_d = MA_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MA_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      din_q   <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      din_q   <= din_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  assign bus_req     = (state_q == MA_REQ);
  assign bus_we      = we_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign cpu_mem_din = din_q;
  assign misalign    = mis_q;
  assign bus_err     = err_q;
  assign cpu_stall   = ((state_q == MA_IDLE) && cpu_req) || (state_q == MA_REQ);

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver queues expectations, monitor checks at negedge.
`timescale 1ns/1ps
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_mem_ren = 1'b0, cpu_mem_wen = 1'b0;
  logic [AW-1:0] cpu_mem_addr = '0;
  logic [DW-1:0] cpu_mem_dout = '0;
  logic [DW-1:0] cpu_mem_din;
  logic          cpu_stall, misalign, bus_req, bus_we, bus_err;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata = '0;
  logic          bus_ack = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_mem_ren(cpu_mem_ren), .cpu_mem_wen(cpu_mem_wen),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_dout(cpu_mem_dout),
    .cpu_mem_din(cpu_mem_din), .cpu_stall(cpu_stall), .misalign(misalign),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata, din;
    int          req, stall, mis, err;
  } exp_t;

  typedef struct {
    string       tag;
    logic        req, stall, mis, err, we;
    logic [31:0] addr, wdata, din;
  } snap_t;

  exp_t  exp_q[$];
  snap_t snap_q[$];

  int          ack_delay_v = 0;
  logic [31:0] rdata_v     = '0;
  logic        force_ack   = 1'b0;
  bit          tb_done     = 1'b0;
  logic [31:0] din_exp     = '0;

  // Memory model: acks after ack_delay_v wait cycles; force_ack injects stray acks.
  int wait_cnt = 0;
  always @(negedge clk) begin
    if (bus_req) begin
      if (wait_cnt == ack_delay_v) begin
        bus_ack   = 1'b1;
        bus_rdata = rdata_v;
        wait_cnt  = 0;
      end else begin
        bus_ack  = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      bus_ack   = force_ack;
      bus_rdata = force_ack ? 32'hFFFF_FFFF : 32'h0;
      wait_cnt  = 0;
    end
  end

  // Monitor / scoreboard
  int n_chk = 0, n_pass = 0;
  int st_cnt = 0, req_cnt = 0, mis_cnt = 0, err_cnt = 0;
  bit unstable = 1'b0;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
  endtask

  initial begin
    snap_t s;
    exp_t  e;
    forever begin
      @(negedge clk);
      if (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        chk({s.tag, "_bus_req"},   bus_req,     s.req);
        chk({s.tag, "_stall"},     cpu_stall,   s.stall);
        chk({s.tag, "_misalign"},  misalign,    s.mis);
        chk({s.tag, "_bus_err"},   bus_err,     s.err);
        chk({s.tag, "_bus_we"},    bus_we,      s.we);
        chk({s.tag, "_bus_addr"},  bus_addr,    s.addr);
        chk({s.tag, "_bus_wdata"}, bus_wdata,   s.wdata);
        chk({s.tag, "_din"},       cpu_mem_din, s.din);
      end
      if (rst) begin
        st_cnt = 0; req_cnt = 0; mis_cnt = 0; err_cnt = 0; unstable = 1'b0;
      end else begin
        if (cpu_stall) st_cnt++;
        if (misalign)  mis_cnt++;
        if (bus_err)   err_cnt++;
        if (bus_req) begin
          if (req_cnt == 0) begin
            cap_we = bus_we; cap_addr = bus_addr; cap_wdata = bus_wdata;
          end else if (bus_we !== cap_we || bus_addr !== cap_addr || bus_wdata !== cap_wdata) begin
            unstable = 1'b1;
          end
          req_cnt++;
        end
        if ((cpu_mem_ren || cpu_mem_wen) && !cpu_stall) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_completion", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("din",         cpu_mem_din, e.din);
            chk("stall_cycles", st_cnt,     e.stall);
            chk("req_cycles",   req_cnt,    e.req);
            chk("misalign_pulses", mis_cnt, e.mis);
            chk("err_pulses",   err_cnt,    e.err);
            if (e.req > 0) begin
              chk("bus_we",     cap_we,    e.we);
              chk("bus_addr",   cap_addr,  e.addr);
              chk("bus_wdata",  cap_wdata, e.wdata);
              chk("bus_stable", unstable,  32'd0);
            end
          end
          st_cnt = 0; req_cnt = 0; mis_cnt = 0; err_cnt = 0; unstable = 1'b0;
        end
      end
      if (tb_done) begin
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Driver: hand-computed expectation for each access, then hold it until the CPU advances.
  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int dly, input logic [31:0] rd, input bit to);
    exp_t e;
    e.we = w; e.addr = a; e.wdata = d; e.mis = 0; e.err = 0;
    if (a[1:0] != 2'b00) begin
      e.req = 0; e.stall = 1; e.mis = 1;
      if (!w) din_exp = 32'h0;
    end else if (to) begin
      e.req = TO; e.stall = TO + 1; e.err = 1;
      din_exp = 32'hDEAD_BEEF;
    end else begin
      e.req = dly + 1; e.stall = dly + 2;
      if (!w) din_exp = rd;
    end
    e.din = din_exp;
    exp_q.push_back(e);
    ack_delay_v = to ? 100000 : dly;
    rdata_v = rd;
    cpu_mem_ren = r; cpu_mem_wen = w; cpu_mem_addr = a; cpu_mem_dout = d;
    for (int i = 0; i <= 600; i++) begin
      @(negedge clk);
      if (!cpu_stall) break;
      if (i == 600) begin
        $display("FAIL access_wait: stall=%0b after 600 cycles, expected release", cpu_stall);
        $fatal(1, "stuck");
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cpu_mem_ren = 1'b0; cpu_mem_wen = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    snap_t s;
    s = '{tag:"reset", req:0, stall:0, mis:0, err:0, we:0, addr:0, wdata:0, din:0};
    snap_q.push_back(s);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle();

    access(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'h1234_5678, 1'b0);  idle();
    access(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 4, 32'h0, 1'b0);  idle();
    access(1'b0, 1'b1, 32'h22, 32'h1111_2222, 0, 32'h0, 1'b0);  idle();
    access(1'b1, 1'b0, 32'h13, 32'h0, 0, 32'hFFFF_FFFF, 1'b0);  idle();
    // Back-to-back load then store (ren & wen both set counts as a write).
    access(1'b1, 1'b0, 32'h40, 32'h0, 1, 32'hA5A5_0001, 1'b0);
    access(1'b1, 1'b1, 32'h44, 32'h0BAD_F00D, 2, 32'h0, 1'b0);  idle();

    // Reset in the middle of a bus cycle, then a stray ack while idle.
    ack_delay_v = 100000;
    cpu_mem_ren = 1'b1; cpu_mem_addr = 32'h60;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_req) break;
    end
    if (!bus_req) begin
      $display("FAIL rst_setup: bus_req=%0b, expected 1", bus_req);
      $fatal(1, "no req");
    end
    @(posedge clk); #1;
    rst = 1'b1; cpu_mem_ren = 1'b0; din_exp = 32'h0;
    s = '{tag:"rst_midreq", req:0, stall:0, mis:0, err:0, we:0, addr:0, wdata:0, din:0};
    snap_q.push_back(s);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; force_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1 force_ack = 1'b0;
    s = '{tag:"late_ack", req:0, stall:0, mis:0, err:0, we:0, addr:0, wdata:0, din:0};
    snap_q.push_back(s);
    idle();
    access(1'b1, 1'b0, 32'h50, 32'h0, 0, 32'h600D_CAFE, 1'b0);  idle();

`ifdef MEM_TIMEOUT_EN
    access(1'b1, 1'b0, 32'h70, 32'h0, 0, 32'h0, 1'b1);  idle();
`endif

    tb_done = 1'b1;
  end

endmodule
